half_shell_pair_scheduler: RTL and testbench

//  Sequences half-shell position-cache reads for one force-evaluation pass.

---
 rtl/half_shell_pair_scheduler_pkg.sv | 18 +
 rtl/half_shell_pair_scheduler_if.sv | 21 ++
 rtl/half_shell_idx_counter.sv | 56 +++++
 rtl/half_shell_pair_scheduler.sv | 152 +++++++++++++++
 tb/tb_half_shell_pair_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/half_shell_pair_scheduler_pkg.sv
// Shared types and constants for the half-shell pair scheduler.
package half_shell_pair_scheduler_pkg;

    localparam int NUM_NEIGHBOR_CELLS  = 13;
    localparam int PARTICLE_ADDR_WIDTH = 7;
    localparam int MAX_PARTICLES       = 100;
    localparam int SLOT_WIDTH          = 4;

    typedef enum logic [1:0] {PS_IDLE, PS_RUN, PS_DONE} pair_sched_state_t;

    typedef logic [PARTICLE_ADDR_WIDTH-1:0] particle_addr_t;
    typedef logic [PARTICLE_ADDR_WIDTH:0]   particle_cnt_t;
    typedef logic [SLOT_WIDTH-1:0]          nb_slot_t;

    localparam nb_slot_t      LAST_SLOT = nb_slot_t'(NUM_NEIGHBOR_CELLS);
    localparam particle_cnt_t MAX_CNT   = particle_cnt_t'(MAX_PARTICLES);

endpackage

// File: rtl/half_shell_pair_scheduler_if.sv
// Read-tuple bus between the pair scheduler and the position caches / PE array.
interface half_shell_pair_scheduler_if;
    import half_shell_pair_scheduler_pkg::*;

    logic           rd_valid;
    logic           rd_ready;
    particle_addr_t rd_home_addr;
    particle_addr_t rd_nb_addr;
    nb_slot_t       rd_nb_slot;
    logic           last_of_home;

    modport master (
        output rd_valid, rd_home_addr, rd_nb_addr, rd_nb_slot, last_of_home,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_home_addr, rd_nb_addr, rd_nb_slot, last_of_home,
        output rd_ready
    );
endinterface

// File: rtl/half_shell_idx_counter.sv
// Next-(h, n, p) generator for the half-shell walk. p is innermost, then the
// slot n, then the home particle h. Slot 0 (home cell) only covers p > h and is
// skipped outright when no such p exists, so the walk never produces a bubble.
module half_shell_idx_counter
    import half_shell_pair_scheduler_pkg::*;
(
    input  logic           restart,
    input  particle_cnt_t  n_cnt,
    input  particle_addr_t cur_h,
    input  nb_slot_t       cur_n,
    input  particle_addr_t cur_p,
    output particle_addr_t nxt_h,
    output nb_slot_t       nxt_n,
    output particle_addr_t nxt_p,
    output logic           nxt_last
);
    particle_cnt_t n_m1;
    particle_cnt_t h_plus2;

    assign n_m1    = n_cnt - particle_cnt_t'(1);
    assign h_plus2 = particle_cnt_t'(cur_h) + particle_cnt_t'(2);

    // Advance the tuple; restart yields the first tuple of a pass (h = 0)
    always_comb begin
        nxt_h = cur_h;
        nxt_n = cur_n;
        nxt_p = cur_p;
        if (restart) begin
            nxt_h = '0;
            if (n_cnt <= particle_cnt_t'(1)) begin
                nxt_n = nb_slot_t'(1);
                nxt_p = '0;
            end else begin
                nxt_n = '0;
                nxt_p = particle_addr_t'(1);
            end
        end else if (particle_cnt_t'(cur_p) != n_m1) begin
            nxt_p = cur_p + particle_addr_t'(1);
        end else if (cur_n != LAST_SLOT) begin
            nxt_n = cur_n + nb_slot_t'(1);
            nxt_p = '0;
        end else begin
            nxt_h = cur_h + particle_addr_t'(1);
            if (h_plus2 >= n_cnt) begin
                nxt_n = nb_slot_t'(1);
                nxt_p = '0;
            end else begin
                nxt_n = '0;
                nxt_p = particle_addr_t'(h_plus2);
            end
        end
    end

    assign nxt_last = (nxt_n == LAST_SLOT) && (particle_cnt_t'(nxt_p) == n_m1);

endmodule

// File: rtl/half_shell_pair_scheduler.sv
// Half-shell position-cache read sequencer for one force-evaluation pass.
// Optional feature macro: PAIR_SCHED_PERF_EN adds transfer/stall counters.
module half_shell_pair_scheduler
    import half_shell_pair_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  particle_cnt_t num_particles,
    half_shell_pair_scheduler_if.master rd,
    output logic          busy,
    output logic          done
`ifdef PAIR_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_xfer_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);
    pair_sched_state_t state_q;
    particle_cnt_t     n_cnt_q;
    particle_addr_t    h_q, p_q;
    nb_slot_t          n_q;
    logic              valid_q, last_q, busy_q, done_q;

    particle_cnt_t     n_clip, n_eff;
    particle_addr_t    nxt_h, nxt_p;
    nb_slot_t          nxt_n;
    logic              nxt_last, restart, start_ok, xfer, final_tuple;

    function automatic particle_cnt_t sat_particles(input particle_cnt_t n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

    assign n_clip      = sat_particles(num_particles);
    assign restart     = (state_q == PS_IDLE);
    assign n_eff       = restart ? n_clip : n_cnt_q;
    assign start_ok    = restart && start && !abort;
    assign xfer        = valid_q && rd.rd_ready && !abort;
    assign final_tuple = last_q && (particle_cnt_t'(h_q) == n_cnt_q - particle_cnt_t'(1));

    half_shell_idx_counter u_idx (
        .restart  (restart),
        .n_cnt    (n_eff),
        .cur_h    (h_q),
        .cur_n    (n_q),
        .cur_p    (p_q),
        .nxt_h    (nxt_h),
        .nxt_n    (nxt_n),
        .nxt_p    (nxt_p),
        .nxt_last (nxt_last)
    );

    // Pass FSM with registered tuple, valid, busy and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_IDLE;
            n_cnt_q <= '0;
            h_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= PS_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                PS_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        n_cnt_q <= n_clip;
                        busy_q  <= 1'b1;
                        if (n_clip == '0) begin
                            // Empty pass: one quiet DONE cycle, then the pulse
                            state_q <= PS_DONE;
                        end else begin
                            state_q <= PS_RUN;
                            valid_q <= 1'b1;
                            h_q     <= nxt_h;
                            n_q     <= nxt_n;
                            p_q     <= nxt_p;
                            last_q  <= nxt_last;
                        end
                    end
                end
                PS_RUN: begin
                    if (xfer) begin
                        if (final_tuple) begin
                            state_q <= PS_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            h_q    <= nxt_h;
                            n_q    <= nxt_n;
                            p_q    <= nxt_p;
                            last_q <= nxt_last;
                        end
                    end
                end
                PS_DONE: begin
                    if (done_q) begin
                        state_q <= PS_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= PS_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd.rd_valid     = valid_q;
    assign rd.rd_home_addr = h_q;
    assign rd.rd_nb_addr   = p_q;
    assign rd.rd_nb_slot   = n_q;
    assign rd.last_of_home = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef PAIR_SCHED_PERF_EN
    // Transfer and stall counters, cleared on each accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_xfer_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else if (start_ok) begin
            perf_xfer_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (xfer)
                perf_xfer_cnt <= perf_xfer_cnt + 32'd1;
            if (valid_q && !rd.rd_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_half_shell_pair_scheduler.sv
// Directed testbench for half_shell_pair_scheduler.
module tb_half_shell_pair_scheduler;
    import half_shell_pair_scheduler_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    particle_cnt_t num_particles = '0;
    logic          busy, done;
`ifdef PAIR_SCHED_PERF_EN
    logic [31:0]   perf_xfer_cnt, perf_stall_cnt;
`endif

    half_shell_pair_scheduler_if bus();

    half_shell_pair_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_particles (num_particles),
        .rd            (bus),
        .busy          (busy),
        .done          (done)
`ifdef PAIR_SCHED_PERF_EN
        ,
        .perf_xfer_cnt (perf_xfer_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int q_t[$], q_l[$];
    int e_t[$], e_l[$];
    int done_cyc, last_xfer_cyc, first_valid_cyc, stall_bad, valid_drop;
    bit busy_c0, busy_after, done_after;

    function automatic int pack_t(input int h, input int n, input int p);
        return (h << 16) | (n << 8) | p;
    endfunction

    function automatic int tuple_at(input int i);
        if (i < 0 || i >= q_t.size()) return -1;
        return q_t[i];
    endfunction

    // Reference walk written straight from the loop description
    function automatic void build_expected(input int n);
        e_t.delete();
        e_l.delete();
        for (int h = 0; h < n; h++)
            for (int s = 0; s <= NUM_NEIGHBOR_CELLS; s++)
                for (int p = 0; p < n; p++) begin
                    if (s == 0 && p <= h) continue;
                    e_t.push_back(pack_t(h, s, p));
                    e_l.push_back((s == NUM_NEIGHBOR_CELLS && p == n - 1) ? 1 : 0);
                end
    endfunction

    function automatic int first_mismatch(input bit prefix_only);
        int m;
        m = (q_t.size() < e_t.size()) ? q_t.size() : e_t.size();
        for (int i = 0; i < m; i++)
            if (q_t[i] != e_t[i] || q_l[i] != e_l[i]) return i;
        if (!prefix_only && q_t.size() != e_t.size()) return m;
        return -1;
    endfunction

    task automatic drive_start(input int np);
        @(posedge clk); #1;
        start = 1'b1;
        num_particles = particle_cnt_t'(np);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Record transfers from the cycle after the accepting edge until done or budget
    task automatic collect(input int mode, input int budget, input int inj_cyc, input int inj_np);
        bit prev_stall;
        int prev_t, prev_l, cur_t;
        q_t.delete(); q_l.delete();
        done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
        stall_bad = 0; valid_drop = 0; busy_after = 1'b1; done_after = 1'b1;
        prev_stall = 1'b0; prev_t = 0; prev_l = 0;
        bus.rd_ready = (mode == 0);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            cur_t = pack_t(int'(bus.rd_home_addr), int'(bus.rd_nb_slot), int'(bus.rd_nb_addr));
            if (cyc == 0) busy_c0 = busy;
            if (prev_stall) begin
                if (!bus.rd_valid) valid_drop++;
                else if (cur_t != prev_t || int'(bus.last_of_home) != prev_l) stall_bad++;
            end
            if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.rd_valid && bus.rd_ready) begin
                q_t.push_back(cur_t);
                q_l.push_back(int'(bus.last_of_home));
                last_xfer_cyc = cyc;
            end
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_t = cur_t;
            prev_l = int'(bus.last_of_home);
            if (done && done_cyc < 0) done_cyc = cyc;
            @(posedge clk); #1;
            start = (cyc + 1 == inj_cyc);
            if (cyc + 1 == inj_cyc) num_particles = particle_cnt_t'(inj_np);
            bus.rd_ready = (mode == 0) ? 1'b1 : (((cyc + 1) % 2) == 1);
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        if (done_cyc >= 0) begin
            @(negedge clk);
            busy_after = busy;
            done_after = done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.rd_valid !== 1'b0 || bus.last_of_home !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_last: got %b%b want 00", bus.rd_valid, bus.last_of_home);
        end
        n_tests++;
        if ({bus.rd_home_addr, bus.rd_nb_addr, bus.rd_nb_slot} !== 18'd0) begin
            n_fail++; $display("FAIL reset_tuple: got %h want 0", {bus.rd_home_addr, bus.rd_nb_addr, bus.rd_nb_slot});
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_particle();
        int mm;
        build_expected(1);
        drive_start(1);
        collect(0, 100, -1, 0);
        mm = first_mismatch(1'b0);
        n_tests++;
        if (q_t.size() != 13) begin n_fail++; $display("FAIL n1_count: got %0d want 13", q_t.size()); end
        n_tests++;
        if (mm != -1) begin n_fail++; $display("FAIL n1_seq: mismatch at %0d got %h want %h", mm, tuple_at(mm), pack_t(0, mm + 1, 0)); end
        n_tests++;
        if (first_valid_cyc != 0 || busy_c0 !== 1'b1) begin
            n_fail++; $display("FAIL n1_latency: valid_cyc %0d busy %b want 0 1", first_valid_cyc, busy_c0);
        end
        n_tests++;
        if (last_xfer_cyc != 12 || done_cyc != 13) begin
            n_fail++; $display("FAIL n1_done: last %0d done %0d want 12 13", last_xfer_cyc, done_cyc);
        end
        n_tests++;
        if (busy_after !== 1'b0 || done_after !== 1'b0) begin
            n_fail++; $display("FAIL n1_after_done: busy %b done %b want 0 0", busy_after, done_after);
        end
    endtask

    task automatic test_three_particles();
        int mm;
        build_expected(3);
        drive_start(3);
        collect(0, 400, 5, 2);
        mm = first_mismatch(1'b0);
        n_tests++;
        if (q_t.size() != 120) begin n_fail++; $display("FAIL n3_count: got %0d want 120", q_t.size()); end
        n_tests++;
        if (mm != -1) begin n_fail++; $display("FAIL n3_seq: mismatch at %0d got %h", mm, tuple_at(mm)); end
        n_tests++;
        if (tuple_at(0) != pack_t(0, 0, 1)) begin n_fail++; $display("FAIL n3_first: got %h want %h", tuple_at(0), pack_t(0, 0, 1)); end
        n_tests++;
        if (tuple_at(81) != pack_t(2, 1, 0)) begin n_fail++; $display("FAIL n3_h2_start: got %h want %h", tuple_at(81), pack_t(2, 1, 0)); end
        n_tests++;
        if (first_valid_cyc != 0 || last_xfer_cyc != 119 || done_cyc != 120) begin
            n_fail++; $display("FAIL n3_timing: first %0d last %0d done %0d want 0 119 120", first_valid_cyc, last_xfer_cyc, done_cyc);
        end
    endtask

    task automatic test_back_to_back_stall();
        int mm;
        build_expected(3);
        drive_start(3);
        collect(1, 600, -1, 0);
        mm = first_mismatch(1'b0);
        n_tests++;
        if (q_t.size() != 120 || mm != -1) begin
            n_fail++; $display("FAIL stall_seq: count %0d mismatch %0d want 120 -1", q_t.size(), mm);
        end
        n_tests++;
        if (stall_bad != 0 || valid_drop != 0) begin
            n_fail++; $display("FAIL stall_hold: changed %0d dropped %0d want 0 0", stall_bad, valid_drop);
        end
        n_tests++;
        if (last_xfer_cyc != 239 || done_cyc != 240) begin
            n_fail++; $display("FAIL stall_done: last %0d done %0d want 239 240", last_xfer_cyc, done_cyc);
        end
`ifdef PAIR_SCHED_PERF_EN
        n_tests++;
        if (perf_xfer_cnt !== 32'd120 || perf_stall_cnt !== 32'd120) begin
            n_fail++; $display("FAIL perf_counts: xfer %0d stall %0d want 120 120", perf_xfer_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_empty_pass();
        drive_start(0);
        collect(0, 20, -1, 0);
        n_tests++;
        if (first_valid_cyc != -1 || q_t.size() != 0) begin
            n_fail++; $display("FAIL n0_valid: first valid %0d count %0d want -1 0", first_valid_cyc, q_t.size());
        end
        n_tests++;
        if (done_cyc != 1 || busy_c0 !== 1'b1) begin
            n_fail++; $display("FAIL n0_done: done cyc %0d busy %b want 1 1", done_cyc, busy_c0);
        end
        n_tests++;
        if (busy_after !== 1'b0 || done_after !== 1'b0) begin
            n_fail++; $display("FAIL n0_after: busy %b done %b want 0 0", busy_after, done_after);
        end
    endtask

    task automatic test_abort();
        int bad, dseen, mm;
        bad = 0; dseen = 0;
        build_expected(4);
        bus.rd_ready = 1'b1;
        drive_start(4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.rd_valid || pack_t(int'(bus.rd_home_addr), int'(bus.rd_nb_slot), int'(bus.rd_nb_addr)) != e_t[i]) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_prefix: bad %0d want 0", bad); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: valid %b busy %b done %b want 0 0 0", bus.rd_valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        n_tests++;
        if (dseen != 0) begin n_fail++; $display("FAIL abort_no_done: pulses %0d want 0", dseen); end
        build_expected(2);
        drive_start(2);
        collect(0, 200, -1, 0);
        mm = first_mismatch(1'b0);
        n_tests++;
        if (q_t.size() != 53 || mm != -1 || tuple_at(0) != pack_t(0, 0, 1)) begin
            n_fail++; $display("FAIL restart_n2: count %0d mismatch %0d first %h want 53 -1 %h", q_t.size(), mm, tuple_at(0), pack_t(0, 0, 1));
        end
    endtask

    task automatic test_reset_midpass_clip();
        int dseen, mm;
        dseen = 0;
        bus.rd_ready = 1'b1;
        drive_start(3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (bus.rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.last_of_home !== 1'b0 ||
            {bus.rd_home_addr, bus.rd_nb_addr, bus.rd_nb_slot} !== 18'd0) begin
            n_fail++; $display("FAIL midreset_outputs: valid %b busy %b tuple %h want 0 0 0", bus.rd_valid, busy,
                               {bus.rd_home_addr, bus.rd_nb_addr, bus.rd_nb_slot});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || bus.rd_valid) dseen++;
        end
        n_tests++;
        if (dseen != 0) begin n_fail++; $display("FAIL midreset_quiet: active cycles %0d want 0", dseen); end
        build_expected(MAX_PARTICLES);
        drive_start(MAX_PARTICLES + 5);
        collect(0, 1500, -1, 0);
        mm = first_mismatch(1'b1);
        n_tests++;
        if (q_t.size() != 1500 || mm != -1) begin
            n_fail++; $display("FAIL clip_seq: count %0d mismatch %0d got %h want 1500 -1", q_t.size(), mm, tuple_at(mm));
        end
        n_tests++;
        if (tuple_at(1398) != pack_t(0, 13, 99) || q_l[1398] != 1 || tuple_at(1399) != pack_t(1, 0, 2)) begin
            n_fail++; $display("FAIL clip_home_wrap: got %h %h want %h %h", tuple_at(1398), tuple_at(1399),
                               pack_t(0, 13, 99), pack_t(1, 0, 2));
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL clip_abort: busy %b valid %b want 0 0", busy, bus.rd_valid);
        end
    endtask

    initial begin
        bus.rd_ready = 1'b0;
        test_reset();
        test_single_particle();
        test_three_particles();
        test_back_to_back_stall();
        test_empty_pass();
        test_abort();
        test_reset_midpass_clip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
